// File: rtl/ddr4_if_pkg.sv
// Shared constants and helpers for the DDR4 write path.
//   DATA_WIDTH/ADDR_WIDTH/CMD_WIDTH/MASK_WIDTH : MIG user-interface widths
//   PACK        : encoder symbols per MIG write word
//   PAGE_WORDS  : write words per interleaver matrix page
//   CNT_W       : width of the write-FIFO occupancy count
package ddr4_if_pkg;

    localparam int DATA_WIDTH = 512;
    localparam int ADDR_WIDTH = 28;
    localparam int CMD_WIDTH  = 3;
    localparam int MASK_WIDTH = DATA_WIDTH / 8;
    localparam int CNT_W      = 9;

    function automatic int pack_words(input int data_w, input int in_w);
        return data_w / in_w;
    endfunction

    function automatic int page_words(input int cols, input int rows);
        return cols * rows;
    endfunction

    localparam int PACK       = pack_words(DATA_WIDTH, 64);
    localparam int PAGE_WORDS = page_words(8, 8);

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO.
//   clk, rst_n      : clock, synchronous active-low reset
//   push, wdata     : write request and data (ignored when full)
//   pop             : consume head word (ignored when empty)
//   rdata           : head word, valid whenever count > 0
//   count           : occupancy 0..DEPTH
//   overflow_err    : sticky, push seen while full
//   underflow_err   : sticky, pop seen while empty
module sync_fifo_fwft
    import ddr4_if_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int WIDTH = 512
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             overflow_err,
    output logic             underflow_err
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             full, empty, do_push, do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Show-ahead read: head word is always presented.
    assign rdata = mem[rd_ptr];

    // Storage carries no reset; occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (push && full)  overflow_err  <= 1'b1;
            if (pop && empty)  underflow_err <= 1'b1;
        end
    end

endmodule

// File: rtl/ddr4_wr_packer.sv
// Packs narrow encoder symbols into MIG write words and buffers them in a
// FWFT FIFO for the DDR4 interleaver controller.
//   ui_clk, rst_n        : clock, synchronous active-low reset
//   in_data/valid/last   : encoder symbol stream; in_last closes a partial word
//   in_ready             : FIFO has room (from registered count only)
//   app_wdf_wren         : controller consumes the head word
//   app_wdf_data/mask    : head word, mask tied to zero
//   wfifo_rcount         : FIFO occupancy
//   page_done            : one-cycle pulse after each full matrix page pushed
//   overflow_err/underflow_err : sticky FIFO error flags
module ddr4_wr_packer
    import ddr4_if_pkg::*;
#(
    parameter int IN_WIDTH   = 64,
    parameter int DATA_WIDTH = ddr4_if_pkg::DATA_WIDTH,
    parameter int FIFO_DEPTH = 256,
    parameter int MATRIX_COL = 8,
    parameter int MATRIX_ROW = 8
) (
    input  logic                    ui_clk,
    input  logic                    rst_n,
    input  logic [IN_WIDTH-1:0]     in_data,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    input  logic                    app_wdf_wren,
    output logic [DATA_WIDTH-1:0]   app_wdf_data,
    output logic [DATA_WIDTH/8-1:0] app_wdf_mask,
    output logic [CNT_W-1:0]        wfifo_rcount,
    output logic                    page_done,
    output logic                    overflow_err,
    output logic                    underflow_err
);

    localparam int P   = pack_words(DATA_WIDTH, IN_WIDTH);
    localparam int PW  = page_words(MATRIX_COL, MATRIX_ROW);
    localparam int LW  = (P > 1) ? $clog2(P) : 1;
    localparam int PGW = $clog2(PW + 1);

    logic [P-1:0][IN_WIDTH-1:0] stage_q, word;
    logic [LW-1:0]              lane_cnt;
    logic [PGW-1:0]             page_cnt;
    logic                       accept, push;

    assign in_ready     = (wfifo_rcount < CNT_W'(FIFO_DEPTH));
    assign accept       = in_valid & in_ready;
    assign push         = accept & (in_last | (lane_cnt == LW'(P - 1)));
    assign app_wdf_mask = '0;

    // Outgoing word: staged lanes below the current one, the live symbol in
    // the current lane, zeros above so a short frame never leaks stale data.
    genvar g;
    generate
        for (g = 0; g < P; g++) begin : g_lane
            assign word[g] = (LW'(g) < lane_cnt)  ? stage_q[g] :
                             (LW'(g) == lane_cnt) ? in_data    : '0;
        end
    endgenerate

    always_ff @(posedge ui_clk) begin
        if (!rst_n) begin
            stage_q   <= '0;
            lane_cnt  <= '0;
            page_cnt  <= '0;
            page_done <= 1'b0;
        end else begin
            page_done <= 1'b0;
            if (accept) begin
                stage_q[lane_cnt] <= in_data;
                lane_cnt          <= push ? '0 : lane_cnt + LW'(1);
            end
            // Page count runs across frames; only reset clears it.
            if (push) begin
                if (page_cnt == PGW'(PW - 1)) begin
                    page_cnt  <= '0;
                    page_done <= 1'b1;
                end else begin
                    page_cnt  <= page_cnt + PGW'(1);
                end
            end
        end
    end

    sync_fifo_fwft #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_wfifo (
        .clk           (ui_clk),
        .rst_n         (rst_n),
        .push          (push),
        .wdata         (word),
        .pop           (app_wdf_wren),
        .rdata         (app_wdf_data),
        .count         (wfifo_rcount),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

endmodule

// File: tb/tb_ddr4_wr_packer.sv
module tb_ddr4_wr_packer;

    localparam int IW    = 64;
    localparam int DW    = 512;
    localparam int DEPTH = 256;
    localparam int PK    = 8;
    localparam int PAGE  = 64;

    logic          ui_clk = 1'b0;
    logic          rst_n;
    logic [IW-1:0] in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic          app_wdf_wren;
    logic [DW-1:0] app_wdf_data;
    logic [DW/8-1:0] app_wdf_mask;
    logic [8:0]    wfifo_rcount;
    logic          page_done;
    logic          overflow_err;
    logic          underflow_err;

    always #5 ui_clk = ~ui_clk;

    ddr4_wr_packer dut (
        .ui_clk        (ui_clk),
        .rst_n         (rst_n),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_last       (in_last),
        .in_ready      (in_ready),
        .app_wdf_wren  (app_wdf_wren),
        .app_wdf_data  (app_wdf_data),
        .app_wdf_mask  (app_wdf_mask),
        .wfifo_rcount  (wfifo_rcount),
        .page_done     (page_done),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    int            checks   = 0;
    int            failures = 0;
    int            pd_seen  = 0;
    logic [DW-1:0] exp_q[$];
    logic [IW-1:0] m_stage [PK];
    int            m_lane, m_page;
    bit            exp_pd, exp_uf;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; the reference model is advanced just after the
    // edge so it lines up with registered DUT state at the next negedge.
    task automatic tick();
        bit acc;
        logic [DW-1:0] w;
        acc = in_valid && (exp_q.size() < DEPTH);
        @(posedge ui_clk);
        #1;
        exp_pd = 1'b0;
        if (acc) begin
            m_stage[m_lane] = in_data;
            if (in_last || m_lane == PK - 1) begin
                w = '0;
                for (int j = 0; j <= m_lane; j++) w[j*IW +: IW] = m_stage[j];
                exp_q.push_back(w);
                m_lane = 0;
                m_page++;
                if (m_page == PAGE) begin
                    m_page = 0;
                    exp_pd = 1'b1;
                end
            end else begin
                m_lane++;
            end
        end
        in_valid     = 1'b0;
        in_last      = 1'b0;
        app_wdf_wren = 1'b0;
    endtask

    task automatic send(input logic [IW-1:0] d, input bit last, input bit wren);
        in_valid     = 1'b1;
        in_data      = d;
        in_last      = last;
        app_wdf_wren = wren;
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        m_lane = 0;
        m_page = 0;
        exp_pd = 1'b0;
        exp_uf = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor: compares every cycle, pops on each consumed word.
    always @(negedge ui_clk) begin
        if (rst_n) begin
            chk("rcount", DW'(wfifo_rcount), DW'(exp_q.size()));
            chk("in_ready", DW'(in_ready), DW'(exp_q.size() < DEPTH));
            if (exp_q.size() > 0) chk("head", app_wdf_data, exp_q[0]);
            chk("page_done", DW'(page_done), DW'(exp_pd));
            chk("overflow_err", DW'(overflow_err), '0);
            chk("underflow_err", DW'(underflow_err), DW'(exp_uf));
            if (page_done) pd_seen++;
            if (app_wdf_wren) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                else exp_uf = 1'b1;
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; app_wdf_wren = 1'b0;
        m_lane = 0; m_page = 0; exp_pd = 1'b0; exp_uf = 1'b0;
        do_reset();
        chk("rst_rcount", DW'(wfifo_rcount), '0);
        chk("rst_page_done", DW'(page_done), '0);
        chk("rst_ovf", DW'(overflow_err), '0);
        chk("rst_unf", DW'(underflow_err), '0);
        chk("rst_in_ready", DW'(in_ready), DW'(1));
        chk("mask", DW'(app_wdf_mask), '0);

        // 1: full word 0x01..0x08, lane 0 at LSB, visible one cycle later
        for (int k = 0; k < PK - 1; k++) send(IW'(k + 1), 1'b0, 1'b0);
        chk("t1_before_push", DW'(wfifo_rcount), '0);
        send(64'h8, 1'b0, 1'b0);
        chk("t1_rcount", DW'(wfifo_rcount), DW'(1));
        chk("t1_word", app_wdf_data, {64'h8, 64'h7, 64'h6, 64'h5, 64'h4, 64'h3, 64'h2, 64'h1});

        // 2: in_last closes a 3-lane word, next symbol starts lane 0
        do_reset();
        send(64'hA1, 1'b0, 1'b0);
        send(64'hA2, 1'b0, 1'b0);
        send(64'hA3, 1'b1, 1'b0);
        chk("t2_rcount", DW'(wfifo_rcount), DW'(1));
        chk("t2_word", app_wdf_data, {320'h0, 64'hA3, 64'hA2, 64'hA1});
        for (int k = 0; k < PK; k++) send(IW'(8'hB0 + k), 1'b0, 1'b0);
        chk("t2_rcount2", DW'(wfifo_rcount), DW'(2));
        app_wdf_wren = 1'b1;
        tick();
        chk("t2_word2", app_wdf_data,
            {64'hB7, 64'hB6, 64'hB5, 64'hB4, 64'hB3, 64'hB2, 64'hB1, 64'hB0});

        // 3: fill to capacity, in_ready drops, one pop reopens it
        do_reset();
        for (int i = 0; i < DEPTH; i++)
            for (int k = 0; k < PK; k++) send(IW'(i * PK + k), 1'b0, 1'b0);
        chk("t3_full_rcount", DW'(wfifo_rcount), DW'(256));
        chk("t3_full_ready", DW'(in_ready), '0);
        send(64'hDEAD, 1'b0, 1'b0);
        chk("t3_still_full", DW'(wfifo_rcount), DW'(256));
        app_wdf_wren = 1'b1;
        tick();
        chk("t3_after_pop", DW'(wfifo_rcount), DW'(255));
        chk("t3_ready", DW'(in_ready), DW'(1));
        chk("t3_ovf", DW'(overflow_err), '0);

        // 4: simultaneous push and pop at count 5
        do_reset();
        for (int n = 0; n < 5 * PK; n++) send(IW'(16'h400 + n), 1'b0, 1'b0);
        chk("t4_rcount5", DW'(wfifo_rcount), DW'(5));
        for (int k = 0; k < PK - 1; k++) send(IW'(16'h500 + k), 1'b0, 1'b0);
        send(64'h507, 1'b0, 1'b1);
        chk("t4_rcount_hold", DW'(wfifo_rcount), DW'(5));
        chk("t4_head_lane0", DW'(app_wdf_data[63:0]), DW'(64'h408));

        // 5: underflow is sticky until reset
        do_reset();
        app_wdf_wren = 1'b1;
        tick();
        chk("t5_unf", DW'(underflow_err), DW'(1));
        chk("t5_rcount", DW'(wfifo_rcount), '0);
        tick(); tick();
        chk("t5_unf_hold", DW'(underflow_err), DW'(1));
        do_reset();
        chk("t5_unf_clr", DW'(underflow_err), '0);

        // 6: page pulses after push 64 and 128, then reset mid-word
        do_reset();
        pd_seen = 0;
        for (int n = 0; n < 130 * PK; n++) send(IW'(n), 1'b0, 1'b0);
        tick();
        chk("t6_pulses", DW'(pd_seen), DW'(2));
        chk("t6_rcount", DW'(wfifo_rcount), DW'(130));
        send(64'hC1, 1'b0, 1'b0);
        send(64'hC2, 1'b0, 1'b0);
        send(64'hC3, 1'b0, 1'b0);
        do_reset();
        chk("t6_rst_rcount", DW'(wfifo_rcount), '0);
        for (int k = 0; k < PK; k++) send(IW'(8'hD0 + k), 1'b0, 1'b0);
        chk("t6_clean_word", app_wdf_data,
            {64'hD7, 64'hD6, 64'hD5, 64'hD4, 64'hD3, 64'hD2, 64'hD1, 64'hD0});
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
